// File: rtl/decode_pkg.sv
// Shared decode types: RISC-V opcodes, ALU op encoding, access widths and the decoded bundle.
// The bundle's immediate is always 64 bits; narrower stages use the low XLEN bits.
package decode_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_32     = 7'b0111011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;

  localparam int ALUOP_W = 6;

  typedef enum logic [ALUOP_W-1:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND,
    ALU_ADDW, ALU_SUBW, ALU_SLLW, ALU_SRLW, ALU_SRAW,
    ALU_EQ, ALU_NE, ALU_LT, ALU_GE, ALU_LTU, ALU_GEU,
    ALU_OUTIMM,
    ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU, ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU,
    ALU_MULW, ALU_DIVW, ALU_DIVUW, ALU_REMW, ALU_REMUW
  } alu_op_e;

  typedef enum logic [1:0] {WDT_8, WDT_16, WDT_32, WDT_64} wdt_e;

  typedef struct packed {
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [63:0] imm;
    alu_op_e     alu_op;
    logic        need_imm;
    logic        reg_wen;
    logic        mem_wen;
    logic        is_load;
    logic        is_branch;
    logic        is_jal;
    logic        is_jalr;
    logic        is_auipc;
    logic        is_ebreak;
    logic        is_unsigned;
    wdt_e        wdt;
    logic        illegal;
  } dec_bundle_t;

endpackage

// File: rtl/decode_if.sv
// Fetch-side and executor-side handshake bundle of the decode stage.
// master = fetch/executor environment, slave = decode stage.
interface decode_if #(
  parameter int XLEN = 64,
  parameter int PC_W = XLEN
);
  import decode_pkg::*;

  logic                in_valid;
  logic                in_ready;
  logic [31:0]         in_inst;
  logic [PC_W-1:0]     in_pc;
  logic                flush;
  logic                out_valid;
  logic                out_ready;
  logic [PC_W-1:0]     out_pc;
  logic [4:0]          out_rd, out_rs1, out_rs2;
  logic [XLEN-1:0]     out_imm;
  logic [ALUOP_W-1:0]  out_alu_op;
  logic                out_need_imm, out_reg_wen, out_mem_wen, out_is_load, out_is_branch;
  logic                out_is_jal, out_is_jalr, out_is_auipc, out_is_ebreak, out_is_unsigned;
  logic [1:0]          out_wdt;
  logic                out_illegal;

  modport master (
    output in_valid, in_inst, in_pc, flush, out_ready,
    input  in_ready, out_valid, out_pc, out_rd, out_rs1, out_rs2, out_imm, out_alu_op,
           out_need_imm, out_reg_wen, out_mem_wen, out_is_load, out_is_branch, out_is_jal,
           out_is_jalr, out_is_auipc, out_is_ebreak, out_is_unsigned, out_wdt, out_illegal
  );

  modport slave (
    input  in_valid, in_inst, in_pc, flush, out_ready,
    output in_ready, out_valid, out_pc, out_rd, out_rs1, out_rs2, out_imm, out_alu_op,
           out_need_imm, out_reg_wen, out_mem_wen, out_is_load, out_is_branch, out_is_jal,
           out_is_jalr, out_is_auipc, out_is_ebreak, out_is_unsigned, out_wdt, out_illegal
  );
endinterface

// File: rtl/decode_logic.sv
// Combinational RV32I/RV64I(+M) instruction decoder: inst -> dec_bundle_t, zero latency.
// No state and no handshake; unused register fields are zeroed, illegal forms never write.
module decode_logic
  import decode_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter bit HAS_M = 1'b1
) (
  input  logic [31:0] inst,
  output dec_bundle_t dec
);

  localparam bit RV64 = (XLEN == 64);

  logic [6:0]  opc, f7;
  logic [2:0]  f3;
  logic [63:0] imm_i, imm_s, imm_b, imm_u, imm_j, shamt6, shamt5;
  logic        ill, use_rd, use_rs1, use_rs2;

  assign opc    = inst[6:0];
  assign f3     = inst[14:12];
  assign f7     = inst[31:25];
  assign imm_i  = {{52{inst[31]}}, inst[31:20]};
  assign imm_s  = {{52{inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_b  = {{51{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm_u  = {{32{inst[31]}}, inst[31:12], 12'd0};
  assign imm_j  = {{43{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
  assign shamt6 = {58'd0, inst[25:20]};
  assign shamt5 = {59'd0, inst[24:20]};

  always_comb begin
    dec     = '0;
    ill     = 1'b0;
    use_rd  = 1'b1;
    use_rs1 = 1'b1;
    use_rs2 = 1'b0;
    unique case (opc)
      OP_LUI:   begin dec.alu_op = ALU_OUTIMM; dec.need_imm = 1'b1; dec.reg_wen = 1'b1; dec.imm = imm_u; use_rs1 = 1'b0; end
      OP_AUIPC: begin dec.is_auipc = 1'b1; dec.need_imm = 1'b1; dec.reg_wen = 1'b1; dec.imm = imm_u; use_rs1 = 1'b0; end
      OP_JAL:   begin dec.is_jal = 1'b1; dec.need_imm = 1'b1; dec.reg_wen = 1'b1; dec.imm = imm_j; use_rs1 = 1'b0; end
      OP_JALR:  begin dec.is_jalr = 1'b1; dec.need_imm = 1'b1; dec.reg_wen = 1'b1; dec.imm = imm_i; ill = (f3 != 3'b000); end
      OP_BRANCH: begin
        dec.is_branch = 1'b1; dec.imm = imm_b; use_rd = 1'b0; use_rs2 = 1'b1;
        dec.is_unsigned = f3[1];
        case (f3)
          3'b000: dec.alu_op = ALU_EQ;
          3'b001: dec.alu_op = ALU_NE;
          3'b100: dec.alu_op = ALU_LT;
          3'b101: dec.alu_op = ALU_GE;
          3'b110: dec.alu_op = ALU_LTU;
          3'b111: dec.alu_op = ALU_GEU;
          default: ill = 1'b1;
        endcase
      end
      OP_LOAD: begin
        dec.is_load = 1'b1; dec.need_imm = 1'b1; dec.reg_wen = 1'b1; dec.imm = imm_i;
        dec.wdt = wdt_e'(f3[1:0]); dec.is_unsigned = f3[2];
        ill = (f3 == 3'b111) || (!RV64 && (f3 == 3'b011 || f3 == 3'b110));
      end
      OP_STORE: begin
        dec.mem_wen = 1'b1; dec.need_imm = 1'b1; dec.imm = imm_s; dec.wdt = wdt_e'(f3[1:0]);
        use_rd = 1'b0; use_rs2 = 1'b1;
        ill = f3[2] || (!RV64 && f3 == 3'b011);
      end
      OP_IMM: begin
        dec.need_imm = 1'b1; dec.reg_wen = 1'b1; dec.imm = imm_i;
        case (f3)
          3'b000: dec.alu_op = ALU_ADD;
          3'b010: dec.alu_op = ALU_SLT;
          3'b011: begin dec.alu_op = ALU_SLTU; dec.is_unsigned = 1'b1; end
          3'b100: dec.alu_op = ALU_XOR;
          3'b110: dec.alu_op = ALU_OR;
          3'b111: dec.alu_op = ALU_AND;
          3'b001: begin
            dec.alu_op = ALU_SLL; dec.imm = shamt6;
            ill = (inst[31:26] != 6'd0) || (!RV64 && inst[25]);
          end
          default: begin
            dec.alu_op = inst[30] ? ALU_SRA : ALU_SRL; dec.imm = shamt6;
            ill = inst[31] || (inst[29:26] != 4'd0) || (!RV64 && inst[25]);
          end
        endcase
      end
      OP_IMM_32: begin
        dec.need_imm = 1'b1; dec.reg_wen = 1'b1; dec.imm = imm_i; ill = !RV64;
        case (f3)
          3'b000: dec.alu_op = ALU_ADDW;
          3'b001: begin dec.alu_op = ALU_SLLW; dec.imm = shamt5; ill = ill || (f7 != 7'b0000000); end
          3'b101: begin
            dec.alu_op = inst[30] ? ALU_SRAW : ALU_SRLW; dec.imm = shamt5;
            ill = ill || (f7 != 7'b0000000 && f7 != 7'b0100000);
          end
          default: ill = 1'b1;
        endcase
      end
      OP_OP: begin
        dec.reg_wen = 1'b1; use_rs2 = 1'b1;
        case (f7)
          7'b0000000: begin
            case (f3)
              3'b000: dec.alu_op = ALU_ADD;
              3'b001: dec.alu_op = ALU_SLL;
              3'b010: dec.alu_op = ALU_SLT;
              3'b011: begin dec.alu_op = ALU_SLTU; dec.is_unsigned = 1'b1; end
              3'b100: dec.alu_op = ALU_XOR;
              3'b101: dec.alu_op = ALU_SRL;
              3'b110: dec.alu_op = ALU_OR;
              default: dec.alu_op = ALU_AND;
            endcase
          end
          7'b0100000: begin
            if (f3 == 3'b000) dec.alu_op = ALU_SUB;
            else if (f3 == 3'b101) dec.alu_op = ALU_SRA;
            else ill = 1'b1;
          end
          7'b0000001: begin
            ill = !HAS_M;
            dec.alu_op = alu_op_e'(ALU_MUL + {3'd0, f3});
            dec.is_unsigned = (f3 == 3'b011) || (f3 == 3'b101) || (f3 == 3'b111);
          end
          default: ill = 1'b1;
        endcase
      end
      OP_32: begin
        dec.reg_wen = 1'b1; use_rs2 = 1'b1; ill = !RV64;
        case ({f7, f3})
          {7'b0000000, 3'b000}: dec.alu_op = ALU_ADDW;
          {7'b0000000, 3'b001}: dec.alu_op = ALU_SLLW;
          {7'b0000000, 3'b101}: dec.alu_op = ALU_SRLW;
          {7'b0100000, 3'b000}: dec.alu_op = ALU_SUBW;
          {7'b0100000, 3'b101}: dec.alu_op = ALU_SRAW;
          {7'b0000001, 3'b000}: begin dec.alu_op = ALU_MULW;  ill = ill || !HAS_M; end
          {7'b0000001, 3'b100}: begin dec.alu_op = ALU_DIVW;  ill = ill || !HAS_M; end
          {7'b0000001, 3'b101}: begin dec.alu_op = ALU_DIVUW; ill = ill || !HAS_M; dec.is_unsigned = 1'b1; end
          {7'b0000001, 3'b110}: begin dec.alu_op = ALU_REMW;  ill = ill || !HAS_M; end
          {7'b0000001, 3'b111}: begin dec.alu_op = ALU_REMUW; ill = ill || !HAS_M; dec.is_unsigned = 1'b1; end
          default: ill = 1'b1;
        endcase
      end
      OP_SYSTEM: begin
        // ecall and all CSR accesses are unimplemented here
        dec.is_ebreak = (inst == INST_EBREAK); ill = (inst != INST_EBREAK);
        use_rd = 1'b0; use_rs1 = 1'b0;
      end
      default: ill = 1'b1;
    endcase
    dec.rd  = use_rd  ? inst[11:7]  : 5'd0;
    dec.rs1 = use_rs1 ? inst[19:15] : 5'd0;
    dec.rs2 = use_rs2 ? inst[24:20] : 5'd0;
    if (ill) begin
      dec.illegal = 1'b1;
      dec.reg_wen = 1'b0;
      dec.mem_wen = 1'b0;
    end
  end

endmodule

// File: rtl/decode_stage.sv
// Decode stage: combinational decode into a 2-entry skid buffer; 1-cycle latency, 1/cycle throughput.
// in_ready depends only on buffer occupancy, so stalls on either side never form a combinational path.
module decode_stage
  import decode_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter bit HAS_M = 1'b1,
  parameter int PC_W  = XLEN
) (
  input  logic   clk,
  input  logic   rst_n,
  decode_if.slave io
);

  dec_bundle_t     dec;
  dec_bundle_t     slot0_q, slot0_d, slot1_q, slot1_d;
  logic [PC_W-1:0] pc0_q, pc0_d, pc1_q, pc1_d;
  logic [1:0]      count_q, count_d;
  logic            push, pop;

  decode_logic #(.XLEN(XLEN), .HAS_M(HAS_M)) u_decode_logic (
    .inst (io.in_inst),
    .dec  (dec)
  );

  assign io.in_ready  = (count_q != 2'd2);
  assign io.out_valid = (count_q != 2'd0);
  assign push = io.in_valid & io.in_ready & ~io.flush;
  assign pop  = io.out_valid & io.out_ready;

  always_comb begin
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    pc0_d   = pc0_q;
    pc1_d   = pc1_q;
    if (pop) begin
      slot0_d = slot1_q;
      pc0_d   = pc1_q;
    end
    // a push lands at the head when the head is empty or being vacated this cycle
    if (push) begin
      if (count_q == 2'd0 || (count_q == 2'd1 && pop)) begin
        slot0_d = dec;
        pc0_d   = io.in_pc;
      end else begin
        slot1_d = dec;
        pc1_d   = io.in_pc;
      end
    end
    count_d = count_q + {1'b0, push} - {1'b0, pop};
    if (io.flush) count_d = 2'd0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= 2'd0;
      slot0_q <= '0;
      slot1_q <= '0;
      pc0_q   <= '0;
      pc1_q   <= '0;
    end else begin
      count_q <= count_d;
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
      pc0_q   <= pc0_d;
      pc1_q   <= pc1_d;
    end
  end

  assign io.out_pc          = pc0_q;
  assign io.out_rd          = slot0_q.rd;
  assign io.out_rs1         = slot0_q.rs1;
  assign io.out_rs2         = slot0_q.rs2;
  assign io.out_imm         = slot0_q.imm[XLEN-1:0];
  assign io.out_alu_op      = slot0_q.alu_op;
  assign io.out_need_imm    = slot0_q.need_imm;
  assign io.out_reg_wen     = slot0_q.reg_wen;
  assign io.out_mem_wen     = slot0_q.mem_wen;
  assign io.out_is_load     = slot0_q.is_load;
  assign io.out_is_branch   = slot0_q.is_branch;
  assign io.out_is_jal      = slot0_q.is_jal;
  assign io.out_is_jalr     = slot0_q.is_jalr;
  assign io.out_is_auipc    = slot0_q.is_auipc;
  assign io.out_is_ebreak   = slot0_q.is_ebreak;
  assign io.out_is_unsigned = slot0_q.is_unsigned;
  assign io.out_wdt         = slot0_q.wdt;
  assign io.out_illegal     = slot0_q.illegal;

endmodule

// File: doc/decode_stage.md
# decode_stage

Pipelined, parametrised decode stage between the instruction-fetch unit and the executor. It accepts fetched instructions over a valid/ready handshake and decodes RV32I/RV64I, plus optionally the full M extension. It registers the decoded bundle behind a 2-entry skid buffer, so both sides can stall independently without a combinational ready path. It supports pipeline flush and flags illegal instructions instead of silently decoding them.

## Interface
- `XLEN`, 64: data width, 32 or 64; RV64-only opcodes (OP_IMM_32, OP_32, ld/lwu/sd) are illegal when 32.
- `HAS_M`, 1: 1 decodes mul/mulh/mulhsu/mulhu/div/divu/rem/remu (+ `*w` forms when `XLEN`=64); 0 makes them illegal.
- `PC_W`, `XLEN`: pc width.
- `clk`  in  1  clock; single clock domain.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  fetch offers an instruction.
- `in_ready`  out  1  stage can accept.
- `in_inst`  in  32  instruction word.
- `in_pc`  in  `PC_W`  its pc.
- `flush`  in  1  discard all held and incoming instructions this cycle.
- `out_valid`  out  1  decoded bundle present.
- `out_ready`  in  1  executor accepts.
- `out_pc`  out  `PC_W`  pc of bundle.
- `out_rd`, `out_rs1`, `out_rs2`  out  5 each  register ids.
- `out_imm`  out  `XLEN`  sign-extended immediate, 0 for R-type.
- `out_alu_op`  out  `ALUOP_W`  encoded ALU op from package.
- `out_need_imm`, `out_reg_wen`, `out_mem_wen`, `out_is_load`, `out_is_branch`, `out_is_jal`, `out_is_jalr`, `out_is_auipc`, `out_is_ebreak`, `out_is_unsigned`  out  1 each  control flags.
- `out_wdt`  out  2  access width: 0=8, 1=16, 2=32, 3=64 bit.
- `out_illegal`  out  1  instruction not implemented under current parameters.

## Operation
- Decode is combinational on `in_inst`; results are captured into the skid buffer on an input handshake (`in_valid & in_ready`).
- Buffer: 2 entries, FIFO order; `count` ∈ {0,1,2}; head drives all `out_*`.
- Illegal instruction:
  - `out_illegal`=1 and `reg_wen`/`mem_wen` forced 0; other fields don't-care.
  - Illegal means unknown opcode, unknown funct3/funct7 combination, a parameter-disabled instruction, or shift imm[5]=1 when `XLEN`=32.
- `lui`: `alu_op`=OUTIMM, imm = U-imm sign-extended to `XLEN`.
- `*w` ops: ALU op distinct from 64-bit form. Result sign-extension belongs to the executor, not here.
- Branch ops: one of EQ/NE/LT/GE/LTU/GEU; `need_imm`=0; imm = B-imm.
- `ebreak`: `is_ebreak`=1, `reg_wen`=0, legal. `ecall` and CSR ops are illegal in this generation.

## Timing
- Reset values:
  - `count`=0, `out_valid`=0, `in_ready`=1.
  - All `out_*` data fields 0.
- `in_ready` = (`count` < 2); registered-state function, no combinational dependence on `out_ready`.
- `out_valid` = (`count` > 0).
- Latency: instruction accepted in cycle N appears on `out_*` in cycle N+1 when buffer was empty.
- Throughput: one per cycle while `out_ready`=1.
- Simultaneous push and pop: `count` unchanged; order preserved.
  - At `count`=2, push cannot occur (`in_ready`=0) even if a pop happens that cycle.
- Flush:
  - Next cycle `count`=0, `out_valid`=0.
  - An input handshake in the flush cycle is discarded.
  - An output handshake in the flush cycle is still counted as consumed by the executor.
- `rst_n` asserted mid-operation: immediate (asynchronous) return to reset values; held entries are lost.
- Output fields are stable while `out_valid & ~out_ready`.

## Structure
- Package `decode_pkg`:
  - opcode constants (OP_IMM … OP_32, SYSTEM);
  - `alu_op_e` enum with `ALUOP_W`, including MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU and their W forms;
  - `wdt_e`;
  - packed struct `dec_bundle_t` holding all decoded fields.
- Sub-module `decode_logic`: purely combinational inst → `dec_bundle_t`, parametrised by `XLEN`/`HAS_M`, instantiated once. The stage top holds only the skid buffer and handshake logic.

## Test plan
- Reset: `rst_n`=0 → `out_valid`=0, `in_ready`=1, all `out_*`=0.
- Basic decode: push 0x00500093 (addi x1,x0,5), `out_ready`=1 → next cycle `out_rd`=1, `out_imm`=5, ADD, `reg_wen`=1, `need_imm`=1.
- M extension: 0x02208033 (mul x0,x1,x2) with `HAS_M`=1 → MUL, `rs1`=1, `rs2`=2, legal; with `HAS_M`=0 → `out_illegal`=1, `reg_wen`=0.
- `XLEN`=32: 0x0000009B (addiw) → `out_illegal`=1; 0x00100073 → `is_ebreak`=1, legal.
- Backpressure: `out_ready`=0, push three instructions back-to-back.
  - Required: `in_ready` falls after second accept and the third is held by fetch.
  - After release, outputs emerge in order, one per cycle.
- Flush with `count`=2 and a concurrent push → next cycle `out_valid`=0, `in_ready`=1; flushed and concurrent instructions never appear.
